// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// shift-subtract divide, one bit per cycle, then a sign fix-up and a one-cycle result pulse.
module alu_muldiv_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    Result,
    output logic                     Busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    localparam logic [OPCODE_LENGTH-1:0] OP_MUL    = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULH   = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULHSU = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULHU  = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIV    = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIVU   = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OP_REM    = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OP_REMU   = OPCODE_LENGTH'(7);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              count_q, count_d;
    logic [2*W-1:0]             acc_q, acc_d;
    logic [W-1:0]               opb_q, opb_d;
    logic [OPCODE_LENGTH-1:0]   op_q, op_d;
    logic                       sign_a_q, sign_a_d;
    logic                       sign_b_q, sign_b_d;
    logic [W-1:0]               result_q, result_d;

    // Issue-side decode of the incoming operation
    logic         in_is_div, in_is_rem, in_signed_a, in_signed_b;
    logic         in_sign_a, in_sign_b, in_div_zero, in_div_ovf;
    logic [W-1:0] in_mag_a, in_mag_b, in_special_res;

    always_comb begin
        in_is_div   = (Operation == OP_DIV) || (Operation == OP_DIVU) ||
                      (Operation == OP_REM) || (Operation == OP_REMU);
        in_is_rem   = (Operation == OP_REM) || (Operation == OP_REMU);
        in_signed_a = (Operation == OP_MUL) || (Operation == OP_MULH) ||
                      (Operation == OP_MULHSU) || (Operation == OP_DIV) ||
                      (Operation == OP_REM);
        in_signed_b = (Operation == OP_MUL) || (Operation == OP_MULH) ||
                      (Operation == OP_DIV) || (Operation == OP_REM);
        in_sign_a   = in_signed_a & SrcA[W-1];
        in_sign_b   = in_signed_b & SrcB[W-1];
        in_mag_a    = in_sign_a ? (-SrcA) : SrcA;
        in_mag_b    = in_sign_b ? (-SrcB) : SrcB;
        in_div_zero = in_is_div && (SrcB == '0);
        in_div_ovf  = ((Operation == OP_DIV) || (Operation == OP_REM)) &&
                      (SrcA == MIN_NEG) && (SrcB == '1);
        // Divide-by-zero wins over overflow; the two cannot coincide anyway
        if (in_div_zero) begin
            in_special_res = in_is_rem ? SrcA : '1;
        end else begin
            in_special_res = in_is_rem ? '0 : SrcA;
        end
    end

    // One iteration of each algorithm, evaluated every CALC cycle
    logic         q_is_div;
    logic [W:0]   mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]   rem_shift;
    logic         div_ge;
    logic [W-1:0] rem_sub, rem_keep;
    logic [2*W-1:0] div_next;

    always_comb begin
        q_is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU) ||
                    (op_q == OP_REM) || (op_q == OP_REMU);
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        mul_next  = {mul_sum, acc_q[W-1:1]};
        rem_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge    = (rem_shift >= {1'b0, opb_q});
        // When div_ge holds the difference is below the divisor, so W bits suffice
        rem_sub   = rem_shift[W-1:0] - opb_q;
        rem_keep  = div_ge ? rem_sub : rem_shift[W-1:0];
        div_next  = {rem_keep, acc_q[W-2:0], div_ge};
    end

    // Sign correction and result selection
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? (-acc_q) : acc_q;
        quo_fix  = (sign_a_q ^ sign_b_q) ? (-acc_q[W-1:0]) : acc_q[W-1:0];
        rem_fix  = sign_a_q ? (-acc_q[2*W-1:W]) : acc_q[2*W-1:W];
        case (op_q)
            OP_MUL:                       fix_res = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d     = Operation;
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    count_d  = '0;
                    if (in_div_zero || in_div_ovf) begin
                        result_d = in_special_res;
                        state_d  = ST_DONE;
                    end else if (in_is_div) begin
                        acc_d   = {{W{1'b0}}, in_mag_a};
                        opb_d   = in_mag_b;
                        state_d = ST_CALC;
                    end else begin
                        // Multiplier sits in the low half and shifts out LSB first
                        acc_d   = {{W{1'b0}}, in_mag_b};
                        opb_d   = in_mag_a;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = q_is_div ? div_next : mul_next;
                if (count_q == LAST_BIT) begin
                    count_d = '0;
                    state_d = ST_FIX;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            ST_FIX: begin
                result_d = fix_res;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush kills whatever is in flight and blocks a same-cycle issue
        if (flush) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            acc_d    = acc_q;
            opb_d    = opb_q;
            op_d     = op_q;
            sign_a_d = sign_a_q;
            sign_b_d = sign_b_q;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign Busy      = ~in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign Result    = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed and randomised checks of the iterative multiply/divide unit:
// reset, signed/unsigned results, special cases, flush/reset aborts and back-to-back issue.
module tb_alu_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        out_valid;
    logic [31:0] Result;
    logic        Busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .flush     (flush),
        .out_valid (out_valid),
        .Result    (Result),
        .Busy      (Busy)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // Independent reference built on the simulator's own signed/unsigned arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] xa, xb;
        logic [63:0]        p;
        logic signed [31:0] sa, sb, sr;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin xa = {{32{a[31]}}, a}; xb = {{32{b[31]}}, b}; p = xa * xb; return p[63:32]; end
            3'd2: begin xa = {{32{a[31]}}, a}; xb = {32'd0, b}; p = xa * xb; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sr = sa / sb; return sr;
            end
            3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sr = sa % sb; return sr;
            end
            default: begin if (b == 32'd0) return a; return a % b; end
        endcase
    endfunction

    // Issues one op and returns the result and the cycle (1 = cycle after issue) of out_valid
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        int n;
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res = Result;
        if (!out_valid) lat = -1;
    endtask

    task automatic settle();
        in_valid = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int busy_err, ov_err;
        logic [31:0] res;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; Operation = 3'd0; SrcA = 32'd7; SrcB = 32'd6;
        repeat (3) @(posedge clk);
        #1;
        $display("reset held: in_ready=%b out_valid=%b busy=%b result=%h", in_ready, out_valid, Busy, Result);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
        total++; if (Result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", Result); end
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy_err = 0; ov_err = 0; res = '0;
        for (int c = 1; c <= 34; c++) begin
            if (Busy !== 1'b1) busy_err++;
            if (out_valid !== (c == 34)) ov_err++;
            if (c == 34) res = Result;
            if (c < 34) begin @(posedge clk); #1; end
        end
        $display("MUL 7*6 after reset: result=%h busy_err=%0d ov_err=%0d", res, busy_err, ov_err);
        total++; if (busy_err != 0) begin bad++; $display("FAIL mul_busy_window bad_cycles=%0d want=0", busy_err); end
        total++; if (ov_err != 0) begin bad++; $display("FAIL mul_out_valid_timing bad_cycles=%0d want=0", ov_err); end
        total++; if (res !== 32'd42) begin bad++; $display("FAIL mul_7x6 got=%h want=0000002a", res); end
        @(posedge clk); #1;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL busy_after_done got=%b want=0", Busy); end
    endtask

    task automatic test_signed_mul();
        logic [2:0]  ops [4];
        logic [31:0] av [4], bv [4], ev [4];
        logic [31:0] res;
        int lat;
        ops = '{3'd1, 3'd3, 3'd2, 3'd0};
        av  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        bv  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0002};
        ev  = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        settle();
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], av[i], bv[i], res, lat);
            $display("mul op=%0d a=%h b=%h result=%h lat=%0d", ops[i], av[i], bv[i], res, lat);
            total++;
            if (res !== ev[i] || lat != 34) begin
                bad++; $display("FAIL mul_vec%0d got=%h lat=%0d want=%h lat=34", i, res, lat, ev[i]);
            end
        end
    endtask

    task automatic test_div_signs();
        logic [2:0]  ops [4];
        logic [31:0] av [4], bv [4], ev [4];
        logic [31:0] res;
        int lat;
        ops = '{3'd4, 3'd6, 3'd5, 3'd7};
        av  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        bv  = '{32'd2, 32'd2, 32'd2, 32'd2};
        ev  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
        settle();
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], av[i], bv[i], res, lat);
            $display("div op=%0d a=%h b=%h result=%h lat=%0d", ops[i], av[i], bv[i], res, lat);
            total++;
            if (res !== ev[i] || lat != 34) begin
                bad++; $display("FAIL div_vec%0d got=%h lat=%0d want=%h lat=34", i, res, lat, ev[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4];
        logic [31:0] av [4], bv [4], ev [4];
        logic [31:0] res;
        int lat;
        ops = '{3'd4, 3'd7, 3'd4, 3'd6};
        av  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        bv  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ev  = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
        settle();
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], av[i], bv[i], res, lat);
            $display("special op=%0d a=%h b=%h result=%h lat=%0d", ops[i], av[i], bv[i], res, lat);
            total++;
            if (res !== ev[i] || lat != 1) begin
                bad++; $display("FAIL special_vec%0d got=%h lat=%0d want=%h lat=1", i, res, lat, ev[i]);
            end
        end
    endtask

    task automatic test_flush();
        int seen;
        logic [31:0] res;
        int lat;
        settle();
        // Flush in CALC at counter 10
        Operation = 3'd5; SrcA = 32'd1000; SrcB = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("flush in CALC: in_ready=%b busy=%b out_valid=%b", in_ready, Busy, out_valid);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_calc_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_calc_no_result pulses=%0d want=0", seen); end
        run_op(3'd0, 32'd3, 32'd3, res, lat);
        $display("MUL 3*3 after flush: result=%h lat=%0d", res, lat);
        total++; if (res !== 32'd9 || lat != 34) begin
            bad++; $display("FAIL mul_after_flush got=%h lat=%0d want=00000009 lat=34", res, lat);
        end
        // Flush in FIX: cycle 33 after issue
        settle();
        Operation = 3'd0; SrcA = 32'd5; SrcB = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("flush in FIX: in_ready=%b out_valid=%b", in_ready, out_valid);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_fix got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        // Flush in DONE: the pulse of that cycle stays visible
        settle();
        run_op(3'd0, 32'd4, 32'd4, res, lat);
        flush = 1'b1;
        #1;
        total++; if (out_valid !== 1'b1 || res !== 32'd16) begin
            bad++; $display("FAIL flush_done_visible got out_valid=%b result=%h want 1/00000010", out_valid, res);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_done_idle got in_ready=%b want=1", in_ready); end
        // Flush in IDLE beats a pending issue
        settle();
        Operation = 3'd0; SrcA = 32'd2; SrcB = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        $display("flush in IDLE with in_valid: busy=%b", Busy);
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL flush_idle_blocks_issue got busy=%b want=0", Busy); end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        logic [31:0] res;
        int lat;
        settle();
        Operation = 3'd5; SrcA = 32'd999; SrcB = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        $display("reset mid-op: in_ready=%b busy=%b out_valid=%b result=%h", in_ready, Busy, out_valid, Result);
        total++; if (in_ready !== 1'b1 || Busy !== 1'b0 || out_valid !== 1'b0 || Result !== 32'd0) begin
            bad++; $display("FAIL reset_mid_op got in_ready=%b busy=%b out_valid=%b result=%h want 1/0/0/0",
                            in_ready, Busy, out_valid, Result);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL reset_mid_op_no_result pulses=%0d want=0", seen); end
        run_op(3'd0, 32'd3, 32'd3, res, lat);
        $display("MUL 3*3 after reset: result=%h lat=%0d", res, lat);
        total++; if (res !== 32'd9 || lat != 34) begin
            bad++; $display("FAIL mul_after_reset got=%h lat=%0d want=00000009 lat=34", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        settle();
        Operation = 3'd0; SrcA = 32'd7; SrcB = 32'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        n = 1;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        $display("b2b first: result=%h lat=%0d", Result, n);
        total++; if (n != 34 || Result !== 32'd42) begin
            bad++; $display("FAIL b2b_first got=%h lat=%0d want=0000002a lat=34", Result, n);
        end
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_gap_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL b2b_second_issue got busy=%b want=1", Busy); end
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        $display("b2b second: result=%h lat=%0d", Result, n);
        total++; if (n != 34 || Result !== 32'd42) begin
            bad++; $display("FAIL b2b_second got=%h lat=%0d want=0000002a lat=34", Result, n);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, exp, res;
        int lat, exp_lat, errs;
        settle();
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            exp = ref_model(op, a, b);
            exp_lat = (op[2] && (b == 32'd0 ||
                       (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
            run_op(op, a, b, res, lat);
            total++;
            if (res !== exp || lat != exp_lat) begin
                bad++; errs++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                         i, op, a, b, res, lat, exp, exp_lat);
            end
        end
        $display("random sweep: 1000 ops, %0d wrong", errs);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
        Operation = '0; SrcA = '0; SrcB = '0;
        test_reset();
        test_signed_mul();
        test_div_signs();
        test_special();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
